// File: rtl/alu_exec_if.sv
// Request/response bus between the ALU decoder side and the execution unit.
// The request channel carries the ALUControl code and both operands; the
// response channel carries the result and its flags. Each channel has its own
// valid/ready pair.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal_op;

  // Decode/writeback side: issues requests and consumes results
  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  // Execution unit side
  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage ALU execution unit: stage 1 registers the request, stage 2
// computes and registers the result with its zero/illegal flags. Stage 2 is
// the output register, so a stalled consumer freezes the whole pipe. The only
// combinational path from inputs to outputs is out_ready -> in_ready.
// WIDTH must match the WIDTH of the connected alu_exec_if.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_exec_if.slave bus
);

  logic             s1_valid;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_illegal;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;

  // A stage may advance when it is empty or the stage after it is moving
  always_comb begin
    s2_adv = !s2_valid || bus.out_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  // ALU on the stage-1 contents; unsupported or unknown codes land in default
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (s1_ctrl)
      3'b000:  alu_res = s1_a + s1_b;
      3'b001:  alu_res = s1_a + ~s1_b + WIDTH'(1);
      3'b010:  alu_res = s1_a & s1_b;
      3'b011:  alu_res = s1_a | s1_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: alu_illegal = 1'b1;
    endcase
  end

  // Stage 1: capture the request whenever the slot is free or draining
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      s1_ctrl  <= bus.alu_control;
      s1_a     <= bus.src_a;
      s1_b     <= bus.src_b;
    end
  end

  // Stage 2: register result and flags; a bubble clears valid but keeps old data
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= alu_res;
        s2_zero    <= !alu_illegal && (alu_res == '0);
        s2_illegal <= alu_illegal;
      end
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid;
  assign bus.result     = s2_result;
  assign bus.zero       = s2_zero;
  assign bus.illegal_op = s2_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a table of single operations with
// hand-computed results, a back-to-back stream with a consumer stall, and a
// reset applied with operations in flight.
module tb_alu_exec_unit;

  logic clk;
  logic rst;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_illegal;
  } vec_t;

  int assert_count = 0;
  int fail_count   = 0;

  vec_t vecs[13];

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offer one request in the current cycle and check it is taken immediately
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = v.ctrl;
    bus.src_a       = v.a;
    bus.src_b       = v.b;
    #1;
    checkOutput({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Single op on an empty pipe: no result one cycle later, result two cycles later
  task automatic runVector(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput({v.name, " out_valid early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({v.name, " result"}, bus.result, v.exp_result);
    checkOutput({v.name, " zero"}, 32'(bus.zero), 32'(v.exp_zero));
    checkOutput({v.name, " illegal_op"}, 32'(bus.illegal_op), 32'(v.exp_illegal));
  endtask

  // Four back-to-back ops with the consumer stalled in cycles 2..6
  task automatic runStream();
    logic [2:0]  ops_c[4];
    logic [31:0] ops_a[4];
    logic [31:0] ops_b[4];
    logic [31:0] exp_r[4];
    logic [31:0] got_q[$];
    logic [31:0] held;
    logic        held_v;
    int          idx;
    int          occ;
    bit          stall;
    ops_c = '{3'b000, 3'b001, 3'b011, 3'b010};
    ops_a = '{32'd10, 32'd20, 32'h100, 32'hFF};
    ops_b = '{32'd1,  32'd5,  32'h001, 32'h0F};
    exp_r = '{32'd11, 32'd15, 32'h101, 32'h0F};
    idx    = 0;
    occ    = 0;
    held   = '0;
    held_v = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      @(negedge clk);
      stall         = (c >= 2) && (c < 7);
      bus.out_ready = !stall;
      if (idx < 4) begin
        bus.in_valid    = 1'b1;
        bus.alu_control = ops_c[idx];
        bus.src_a       = ops_a[idx];
        bus.src_b       = ops_b[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        checkOutput("stall in_ready", 32'(bus.in_ready), 32'(occ < 2));
        checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
        if (held_v) checkOutput("stall result hold", bus.result, held);
        held   = bus.result;
        held_v = bus.out_valid;
      end else begin
        held_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.result);
        occ--;
      end
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        occ++;
      end
    end
    checkOutput("stream result count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      checkOutput($sformatf("stream result %0d", i), got_q[i], exp_r[i]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("stream no duplicate", 32'(bus.out_valid), 32'd0);
  endtask

  // Two ops in flight plus one offered on the reset edge; all must vanish
  task automatic runResetFlush();
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = 3'b000;
    bus.src_a       = 32'd100;
    bus.src_b       = 32'd1;
    @(negedge clk);
    bus.src_a       = 32'd200;
    @(negedge clk);
    rst             = 1'b1;
    bus.src_a       = 32'd300;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("flush out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush result", bus.result, 32'd0);
    checkOutput("flush zero", 32'(bus.zero), 32'd0);
    checkOutput("flush illegal_op", 32'(bus.illegal_op), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("flush stays empty %0d", i), 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{"add 5+7",        3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{"sub equal",      3'b001, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0};
    vecs[2]  = '{"add wrap",       3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[3]  = '{"slt -1<1",       3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[4]  = '{"slt 1<-1",       3'b101, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{"and",            3'b010, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0};
    vecs[6]  = '{"or",             3'b011, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1'b0};
    vecs[7]  = '{"illegal 111",    3'b111, 32'd3,        32'd4,        32'd0,        1'b0, 1'b1};
    vecs[8]  = '{"add after ill",  3'b000, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0};
    vecs[9]  = '{"illegal 100",    3'b100, 32'd0,        32'd0,        32'd0,        1'b0, 1'b1};
    vecs[10] = '{"illegal 110",    3'b110, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1};
    vecs[11] = '{"sub negative",   3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[12] = '{"slt equal",      3'b101, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.alu_control = 3'b000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset zero", 32'(bus.zero), 32'd0);
    checkOutput("reset illegal_op", 32'(bus.illegal_op), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      runVector(vecs[i]);
    end

    runStream();
    runResetFlush();
    runVector('{"add after rst", 3'b000, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0});

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
